// File: rtl/inst_fetch_unit.sv
// Instruction fetch/issue sequencer: fetches one word at pc, holds it in op until the datapath retires it.
// Latency: one cycle from a sampled imem_ack to op_valid; one cycle from exec_done to the next imem_req.
// Backpressure: imem_req is held until imem_ack is sampled; op is held until exec_done is sampled.
//
// Optional feature macro: IFU_HALT_EN (halt-instruction detection and the HALT state).
//
// Ports:
//   clk, rst                 - clock (rising edge), asynchronous active-high reset
//   imem_req, imem_addr      - instruction read request, address (always equals pc)
//   imem_ack, imem_rdata     - read response valid, instruction word
//   op, op_valid             - instruction register to the decoder, valid while issuing
//   exec_done                - datapath finished the instruction in op
//   branch_taken/_target     - redirect, sampled only with exec_done
//   resume                   - leave HALT (only with IFU_HALT_EN)
//   pc, halted, retired      - program counter, halt status, retired-instruction count
module inst_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] op,
  output logic        op_valid,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        resume,
  output logic [15:0] pc,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t state, state_nxt;
  logic   fetch_fire;
  logic   retire_fire;
  logic   is_halt;
  logic   resume_ok;

  // Handshakes only count in the state that owns them; strays elsewhere are dropped.
  assign fetch_fire  = (state == FETCH) && imem_ack;
  assign retire_fire = (state == ISSUE) && exec_done;

`ifdef IFU_HALT_EN
  assign is_halt   = (op[15:14] == 2'b11) && (op[7:4] == 4'b1111);
  assign resume_ok = resume;
`else
  // Halt words retire like any other instruction; HALT is never entered.
  logic unused_resume;
  assign unused_resume = resume;
  assign is_halt       = 1'b0;
  assign resume_ok     = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs decode from state alone, so the async reset drops imem_req at once.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    op_valid  = 1'b0;
    halted    = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        op_valid = 1'b1;
        if (exec_done) begin
          state_nxt = is_halt ? HALT : FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (resume_ok) begin
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign imem_addr = pc;

  // pc and retired advance on every retirement, including the halt word itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      op      <= 16'h0000;
      retired <= 16'h0000;
    end else begin
      if (fetch_fire) begin
        op <= imem_rdata;
      end
      if (retire_fire) begin
        pc      <= branch_taken ? branch_target : pc + 16'd1;
        retired <= retired + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed scenarios plus randomized fetch/issue traffic.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: random ack and exec_done delays exercise held requests and held ops.
module tb_inst_fetch_unit;

  localparam logic [15:0] RPC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] op;
  logic        op_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        resume;
  logic [15:0] pc;
  logic        halted;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .op(op), .op_valid(op_valid),
    .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .resume(resume), .pc(pc), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic bit halt_word(input logic [15:0] w);
`ifdef IFU_HALT_EN
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; exec_done = 1'b0;
    branch_taken = 1'b0; branch_target = 16'h0; resume = 1'b0;
    cyc(); cyc();
    checks++; if (pc !== RPC) begin errors++; $display("FAIL rst_pc: got %h want %h", pc, RPC); end
    checks++; if (op !== 16'h0000) begin errors++; $display("FAIL rst_op: got %h want 0000", op); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rst_op_valid: got %b want 0", op_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    checks++; if (retired !== 16'h0000) begin errors++; $display("FAIL rst_retired: got %h want 0000", retired); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_first_fetch_and_branch();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ff_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL ff_addr: got %h want 0000", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 16'hC0C0;
    cyc();
    imem_ack = 1'b0;
    checks++; if (op !== 16'hC0C0) begin errors++; $display("FAIL ff_op: got %h want c0c0", op); end
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL ff_op_valid: got %b want 1", op_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ff_req_drop: got %b want 0", imem_req); end
    // stray ack and branch inputs while issuing must not disturb anything
    imem_ack = 1'b1; imem_rdata = 16'h5555; branch_taken = 1'b1; branch_target = 16'hBEEF;
    cyc(); cyc();
    imem_ack = 1'b0;
    checks++; if (op !== 16'hC0C0) begin errors++; $display("FAIL iss_op_hold: got %h want c0c0", op); end
    checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL iss_pc_hold: got %h want 0000", pc); end
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
    cyc();
    exec_done = 1'b0; branch_taken = 1'b0;
    checks++; if (pc !== 16'h0040) begin errors++; $display("FAIL br_pc: got %h want 0040", pc); end
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL br_retired: got %h want 0001", retired); end
    checks++; if (imem_addr !== 16'h0040 || imem_req !== 1'b1) begin errors++; $display("FAIL br_next_fetch: got req=%b addr=%h want req=1 addr=0040", imem_req, imem_addr); end
  endtask

  task automatic test_fetch_stall();
    for (int i = 0; i < 3; i++) begin
      exec_done = 1'b1; branch_taken = 1'b1; branch_target = 16'h1234;
      cyc();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL stall_%0d: got req=%b addr=%h want req=1 addr=0040", i, imem_req, imem_addr); end
    end
    exec_done = 1'b0; branch_taken = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h1111;
    cyc();
    imem_ack = 1'b0;
    checks++; if (op !== 16'h1111 || op_valid !== 1'b1) begin errors++; $display("FAIL stall_op: got %h/%b want 1111/1", op, op_valid); end
    exec_done = 1'b1;
    cyc();
    exec_done = 1'b0;
    checks++; if (pc !== 16'h0041 || retired !== 16'd2) begin errors++; $display("FAIL stall_retire: got pc=%h ret=%h want 0041/0002", pc, retired); end
  endtask

  task automatic test_wrap();
    imem_ack = 1'b1; imem_rdata = 16'h2222;
    cyc();
    imem_ack = 1'b0; exec_done = 1'b1; branch_taken = 1'b1; branch_target = 16'hFFFF;
    cyc();
    exec_done = 1'b0; branch_taken = 1'b0;
    checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr: got %h want ffff", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 16'h3333;
    cyc();
    imem_ack = 1'b0; exec_done = 1'b1;
    cyc();
    exec_done = 1'b0;
    checks++; if (pc !== 16'h0000 || retired !== 16'd4) begin errors++; $display("FAIL wrap_pc: got pc=%h ret=%h want 0000/0004", pc, retired); end
  endtask

  task automatic test_halt();
    imem_ack = 1'b1; imem_rdata = 16'hC0F0;
    cyc();
    imem_ack = 1'b0; exec_done = 1'b1;
    cyc();
    exec_done = 1'b0;
`ifdef IFU_HALT_EN
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_enter: got halted=%b req=%b want 1/0", halted, imem_req); end
    checks++; if (pc !== 16'h0001 || retired !== 16'd5) begin errors++; $display("FAIL halt_pc: got pc=%h ret=%h want 0001/0005", pc, retired); end
    imem_ack = 1'b1; imem_rdata = 16'h7777; exec_done = 1'b1;
    cyc(); cyc();
    imem_ack = 1'b0; exec_done = 1'b0;
    checks++; if (halted !== 1'b1 || op !== 16'hC0F0 || op_valid !== 1'b0 || pc !== 16'h0001) begin errors++; $display("FAIL halt_hold: got halted=%b op=%h vld=%b pc=%h want 1/c0f0/0/0001", halted, op, op_valid, pc); end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin errors++; $display("FAIL halt_resume: got halted=%b req=%b addr=%h want 0/1/0001", halted, imem_req, imem_addr); end
`else
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin errors++; $display("FAIL nohalt_next: got halted=%b req=%b addr=%h want 0/1/0001", halted, imem_req, imem_addr); end
    checks++; if (retired !== 16'd5) begin errors++; $display("FAIL nohalt_retired: got %h want 0005", retired); end
`endif
  endtask

  task automatic test_reset_mid_fetch();
    cyc();
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mrst_req_async: got %b want 0", imem_req); end
    checks++; if (pc !== RPC || retired !== 16'd0 || op !== 16'h0000) begin errors++; $display("FAIL mrst_state: got pc=%h ret=%h op=%h want %h/0000/0000", pc, retired, op, RPC); end
    imem_ack = 1'b1; imem_rdata = 16'hABCD;
    cyc();
    rst = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mrst_idle_req: got %b want 0", imem_req); end
    cyc();
    imem_ack = 1'b0;
    checks++; if (op !== 16'h0000 || imem_req !== 1'b1 || imem_addr !== RPC) begin errors++; $display("FAIL mrst_restart: got op=%h req=%b addr=%h want 0000/1/%h", op, imem_req, imem_addr, RPC); end
    imem_ack = 1'b1; imem_rdata = 16'h5A5A;
    cyc();
    imem_ack = 1'b0;
    checks++; if (op !== 16'h5A5A || op_valid !== 1'b1) begin errors++; $display("FAIL mrst_fetch: got %h/%b want 5a5a/1", op, op_valid); end
    exec_done = 1'b1;
    cyc();
    exec_done = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h6B6B;
    cyc();
    imem_ack = 1'b0;
    // reset while issuing abandons the instruction even with exec_done present
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 16'h0777;
    #2 rst = 1'b1;
    #1;
    checks++; if (pc !== RPC || retired !== 16'd0 || op_valid !== 1'b0) begin errors++; $display("FAIL irst_state: got pc=%h ret=%h vld=%b want %h/0000/0", pc, retired, op_valid, RPC); end
    cyc();
    rst = 1'b0; exec_done = 1'b0; branch_taken = 1'b0;
    cyc();
    checks++; if (imem_req !== 1'b1 || imem_addr !== RPC || retired !== 16'd0) begin errors++; $display("FAIL irst_restart: got req=%b addr=%h ret=%h want 1/%h/0000", imem_req, imem_addr, retired, RPC); end
  endtask

  task automatic test_random();
    logic [15:0] m_pc;
    logic [15:0] m_ret;
    logic [15:0] w;
    logic [15:0] tgt;
    bit          tk;
    int          d;
    m_pc = RPC; m_ret = 16'd0;
    for (int n = 0; n < 150; n++) begin
      d = int'($urandom_range(0, 3));
      for (int i = 0; i < d; i++) begin
        imem_ack = 1'b0;
        exec_done = 1'($urandom); branch_taken = 1'($urandom); branch_target = 16'($urandom);
        cyc();
        checks++; if (imem_req !== 1'b1 || imem_addr !== m_pc) begin errors++; $display("FAIL rnd_wait[%0d]: got req=%b addr=%h want 1/%h", n, imem_req, imem_addr, m_pc); end
      end
      exec_done = 1'b0; branch_taken = 1'b0;
      w = 16'($urandom);
      if ($urandom_range(0, 5) == 0) w = {2'b11, w[13:8], 4'hF, w[3:0]};
      imem_ack = 1'b1; imem_rdata = w;
      cyc();
      imem_ack = 1'b0;
      checks++; if (op !== w || op_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL rnd_issue[%0d]: got op=%h vld=%b req=%b want %h/1/0", n, op, op_valid, imem_req, w); end
      d = int'($urandom_range(0, 3));
      for (int i = 0; i < d; i++) begin
        imem_ack = 1'($urandom); imem_rdata = 16'($urandom);
        branch_taken = 1'($urandom); branch_target = 16'($urandom);
        cyc();
        checks++; if (op !== w || op_valid !== 1'b1 || pc !== m_pc) begin errors++; $display("FAIL rnd_hold[%0d]: got op=%h vld=%b pc=%h want %h/1/%h", n, op, op_valid, pc, w, m_pc); end
      end
      imem_ack = 1'b0;
      tk = 1'($urandom); tgt = 16'($urandom);
      exec_done = 1'b1; branch_taken = tk; branch_target = tgt;
      cyc();
      exec_done = 1'b0; branch_taken = 1'b0;
      m_pc = tk ? tgt : m_pc + 16'd1;
      m_ret = m_ret + 16'd1;
      checks++; if (pc !== m_pc || retired !== m_ret) begin errors++; $display("FAIL rnd_retire[%0d]: got pc=%h ret=%h want %h/%h", n, pc, retired, m_pc, m_ret); end
      if (halt_word(w)) begin
        d = int'($urandom_range(0, 3));
        for (int i = 0; i < d; i++) begin
          imem_ack = 1'($urandom); exec_done = 1'($urandom);
          cyc();
          checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== m_pc) begin errors++; $display("FAIL rnd_halt[%0d]: got halted=%b req=%b pc=%h want 1/0/%h", n, halted, imem_req, pc, m_pc); end
        end
        imem_ack = 1'b0; exec_done = 1'b0; resume = 1'b1;
        cyc();
        resume = 1'b0;
      end
      checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== m_pc) begin errors++; $display("FAIL rnd_next[%0d]: got halted=%b req=%b addr=%h want 0/1/%h", n, halted, imem_req, imem_addr, m_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch_and_branch();
    test_fetch_stall();
    test_wrap();
    test_halt();
    test_reset_mid_fetch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
